// File: rtl/uart_tx_arbiter.sv
// Round-robin transmit scheduler feeding one UART serializer.
// It latches the winning byte, emits 10 bit ticks per frame, then holds an idle gap before the next frame.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IDLE_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_enable,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] data_wr,
  output logic       bit_tick,
  output logic       frame_start,
  output logic       busy,
  output logic       grant_id
);

  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_LEN = IDLE_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_grant;
  logic             winner;
  logic             can_accept;
  logic             accept;

  // A lone requester always wins; contention goes to whoever was not served last.
  always_comb begin
    winner     = req1_valid;
    if (req0_valid && req1_valid)
      winner = ~last_grant;
    can_accept = (state == IDLE) && tx_enable;
  end

  assign req0_ready  = can_accept & req0_valid & ~winner;
  assign req1_ready  = can_accept & req1_valid & winner;
  assign accept      = req0_ready | req1_ready;

  assign bit_tick    = (state == SHIFT) && (cnt == '0);
  assign frame_start = bit_tick && (bit_idx == 4'd0);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data_wr    <= 8'h00;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      bit_idx    <= 4'd0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_wr    <= winner ? req1_data : req0_data;
            grant_id   <= winner;
            last_grant <= winner;
            cnt        <= '0;
            bit_idx    <= 4'd0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // The stop bit period ends here; a zero-length gap returns straight to IDLE.
            if (bit_idx == 4'd9) begin
              bit_idx <= 4'd0;
              gap_cnt <= '0;
              state   <= (IDLE_BITS > 0) ? GAP : IDLE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance 0 has a one-bit idle gap, instance 1 has none.
// A frame-timing model is compared every cycle; directed tests pin literal timings.
module tb_uart_tx_arbiter;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic       tx_enable [2];
  logic       req0_valid [2];
  logic       req1_valid [2];
  logic       req0_ready [2];
  logic       req1_ready [2];
  logic       bit_tick [2];
  logic       frame_start [2];
  logic       busy [2];
  logic       grant_id [2];
  logic [7:0] req0_data [2];
  logic [7:0] req1_data [2];
  logic [7:0] data_wr [2];

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .IDLE_BITS(1)) dut_gap (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable[0]),
    .req0_valid(req0_valid[0]), .req0_data(req0_data[0]), .req0_ready(req0_ready[0]),
    .req1_valid(req1_valid[0]), .req1_data(req1_data[0]), .req1_ready(req1_ready[0]),
    .data_wr(data_wr[0]), .bit_tick(bit_tick[0]), .frame_start(frame_start[0]),
    .busy(busy[0]), .grant_id(grant_id[0])
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .IDLE_BITS(0)) dut_nogap (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable[1]),
    .req0_valid(req0_valid[1]), .req0_data(req0_data[1]), .req0_ready(req0_ready[1]),
    .req1_valid(req1_valid[1]), .req1_data(req1_data[1]), .req1_ready(req1_ready[1]),
    .data_wr(data_wr[1]), .bit_tick(bit_tick[1]), .frame_start(frame_start[1]),
    .busy(busy[1]), .grant_id(grant_id[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: a frame is just "m_el cycles into a busy window of frame_len cycles".
  int         m_el [2];
  logic       m_busy [2];
  logic       m_last [2];
  logic       m_grant [2];
  logic [7:0] m_data [2];

  function automatic int frame_len(input int i);
    return (10 + ((i == 0) ? 1 : 0)) * CPB;
  endfunction

  function automatic logic exp_win(input int i);
    if (req0_valid[i] && req1_valid[i]) return !m_last[i];
    return req1_valid[i];
  endfunction

  function automatic logic exp_rdy(input int i, input int n);
    logic v;
    v = (n == 0) ? req0_valid[i] : req1_valid[i];
    return !m_busy[i] && tx_enable[i] && v && (exp_win(i) == (n == 1));
  endfunction

  function automatic logic exp_tick(input int i);
    return m_busy[i] && (m_el[i] < 10 * CPB) && ((m_el[i] % CPB) == 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic w;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_el[i] <= 0; m_data[i] <= 8'h00; m_grant[i] <= 1'b0; m_last[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          m_el[i] <= m_el[i] + 1;
          if (m_el[i] + 1 == frame_len(i)) m_busy[i] <= 1'b0;
        end else if (exp_rdy(i, 0) || exp_rdy(i, 1)) begin
          w = exp_win(i);
          m_busy[i]  <= 1'b1;
          m_el[i]    <= 0;
          m_data[i]  <= w ? req1_data[i] : req0_data[i];
          m_grant[i] <= w;
          m_last[i]  <= w;
        end
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("u%0d req0_ready", i), 32'(req0_ready[i]), 32'(exp_rdy(i, 0)));
        checkOutput($sformatf("u%0d req1_ready", i), 32'(req1_ready[i]), 32'(exp_rdy(i, 1)));
        checkOutput($sformatf("u%0d bit_tick", i), 32'(bit_tick[i]), 32'(exp_tick(i)));
        checkOutput($sformatf("u%0d frame_start", i), 32'(frame_start[i]), 32'(m_busy[i] && m_el[i] == 0));
        checkOutput($sformatf("u%0d busy", i), 32'(busy[i]), 32'(m_busy[i]));
        checkOutput($sformatf("u%0d grant_id", i), 32'(grant_id[i]), 32'(m_grant[i]));
        checkOutput($sformatf("u%0d data_wr", i), 32'(data_wr[i]), 32'(m_data[i]));
      end
    end
  end

  // Event log for the instance selected by mon, sampled at negedge with cyc = posedges so far.
  typedef struct {int c; int id; int d;} acc_t;
  int   cyc = 0;
  int   mon = 0;
  acc_t acc_q[$];
  int   tick_q[$];
  int   fs_q[$];
  int   low_q[$];
  int   busy_cnt, both_rdy, low_run;
  logic prev_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bit_tick[mon]) tick_q.push_back(cyc);
    if (frame_start[mon]) fs_q.push_back(cyc);
    if (req0_ready[mon] && req0_valid[mon]) acc_q.push_back('{cyc, 0, int'(req0_data[mon])});
    if (req1_ready[mon] && req1_valid[mon]) acc_q.push_back('{cyc, 1, int'(req1_data[mon])});
    if (req0_ready[mon] && req1_ready[mon]) both_rdy++;
    if (busy[mon]) begin
      busy_cnt++;
      if (!prev_busy && low_run > 0) low_q.push_back(low_run);
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_busy = busy[mon];
  end

  task automatic clearLog();
    acc_q.delete(); tick_q.delete(); fs_q.delete(); low_q.delete();
    busy_cnt = 0; both_rdy = 0; low_run = 0; prev_busy = busy[mon];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int u, input logic en, input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1);
    tx_enable[u] = en;
    req0_valid[u] = v0; req0_data[u] = d0;
    req1_valid[u] = v1; req1_data[u] = d1;
  endtask

  task automatic doReset();
    step();
    for (int u = 0; u < 2; u++) applyStimulus(u, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic waitAccepts(input int n, input int max_cycles);
    int k = 0;
    while (acc_q.size() < n && k < max_cycles) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput($sformatf("accepts reached %0d", n), 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic waitTicks(input int n, input int max_cycles);
    int k = 0;
    while (tick_q.size() < n && k < max_cycles) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput($sformatf("ticks reached %0d", n), 32'(tick_q.size() >= n), 32'd1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad, en_cyc, n0;
    for (int u = 0; u < 2; u++) applyStimulus(u, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #2 reset_n = 1'b0;
    #1 cmp_on = 1'b1;
    #20;
    checkOutput("reset busy", 32'(busy[0]), 32'd0);
    checkOutput("reset data_wr", 32'(data_wr[0]), 32'h00);
    checkOutput("reset grant_id", 32'(grant_id[0]), 32'd0);
    reset_n = 1'b1;

    // Single frame from requester 0.
    $display("[TB] single frame A5");
    mon = 0; doReset(); clearLog();
    applyStimulus(0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00);
    waitAccepts(1, 20); step();
    applyStimulus(0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
    repeat (60) step();
    checkOutput("t1 accepts", 32'(acc_q.size()), 32'd1);
    checkOutput("t1 tick count", 32'(tick_q.size()), 32'd10);
    checkOutput("t1 busy cycles", 32'(busy_cnt), 32'd44);
    checkOutput("t1 data_wr", 32'(data_wr[0]), 32'hA5);
    checkOutput("t1 grant_id", 32'(grant_id[0]), 32'd0);
    checkOutput("t1 frame_start count", 32'(fs_q.size()), 32'd1);
    if (acc_q.size() == 1 && tick_q.size() == 10 && fs_q.size() == 1) begin
      checkOutput("t1 first tick latency", 32'(tick_q[0] - acc_q[0].c), 32'd1);
      checkOutput("t1 frame_start on first tick", 32'(fs_q[0]), 32'(tick_q[0]));
      bad = 0;
      for (int k = 1; k < 10; k++) if (tick_q[k] - tick_q[k-1] != 4) bad++;
      checkOutput("t1 tick spacing errors", 32'(bad), 32'd0);
    end

    // Both requesters contend continuously.
    $display("[TB] alternating grants");
    doReset(); clearLog();
    applyStimulus(0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
    waitAccepts(4, 4 * 46 + 5); step();
    applyStimulus(0, 1'b1, 1'b0, 8'h11, 1'b0, 8'h22);
    repeat (50) step();
    checkOutput("t2 accepts", 32'(acc_q.size()), 32'd4);
    checkOutput("t2 both ready", 32'(both_rdy), 32'd0);
    if (acc_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("t2 grant %0d", k), 32'(acc_q[k].id), 32'(k % 2));
        checkOutput($sformatf("t2 data %0d", k), 32'(acc_q[k].d), (k % 2) ? 32'h22 : 32'h11);
      end
      for (int k = 1; k < 4; k++)
        checkOutput($sformatf("t2 period %0d", k), 32'(acc_q[k].c - acc_q[k-1].c), 32'd45);
    end

    // Only requester 1.
    $display("[TB] requester 1 only");
    clearLog();
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C);
    waitAccepts(3, 150); step();
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h3C);
    repeat (50) step();
    n0 = 0;
    foreach (acc_q[k]) if (acc_q[k].id != 1) n0++;
    checkOutput("t3 accepts", 32'(acc_q.size()), 32'd3);
    checkOutput("t3 req0 wins", 32'(n0), 32'd0);
    checkOutput("t3 grant_id", 32'(grant_id[0]), 32'd1);

    // Enable drops mid-frame.
    $display("[TB] tx_enable gating");
    doReset(); clearLog();
    applyStimulus(0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
    waitTicks(5, 40); step();
    tx_enable[0] = 1'b0;
    repeat (60) step();
    checkOutput("t4 ticks", 32'(tick_q.size()), 32'd10);
    checkOutput("t4 accepts while disabled", 32'(acc_q.size()), 32'd1);
    checkOutput("t4 idle", 32'(busy[0]), 32'd0);
    tx_enable[0] = 1'b1;
    en_cyc = cyc;
    waitAccepts(2, 5);
    if (acc_q.size() == 2) checkOutput("t4 accept cycle", 32'(acc_q[1].c), 32'(en_cyc));
    step();
    applyStimulus(0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00);
    repeat (50) step();

    // Reset in the middle of a frame.
    $display("[TB] reset mid-frame");
    doReset(); clearLog();
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3);
    waitAccepts(1, 20); step();
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hC3);
    waitTicks(3, 30); step();
    reset_n = 1'b0;
    #1;
    checkOutput("t5 busy in reset", 32'(busy[0]), 32'd0);
    checkOutput("t5 tick in reset", 32'(bit_tick[0]), 32'd0);
    checkOutput("t5 data_wr in reset", 32'(data_wr[0]), 32'h00);
    checkOutput("t5 grant in reset", 32'(grant_id[0]), 32'd0);
    clearLog();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (20) step();
    checkOutput("t5 ticks after reset", 32'(tick_q.size()), 32'd0);
    checkOutput("t5 busy after reset", 32'(busy_cnt), 32'd0);
    applyStimulus(0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
    waitAccepts(1, 5);
    if (acc_q.size() >= 1) checkOutput("t5 first winner", 32'(acc_q[0].id), 32'd0);
    step();
    applyStimulus(0, 1'b1, 1'b0, 8'h11, 1'b0, 8'h22);
    repeat (50) step();

    // No idle gap: back-to-back frames on instance 1.
    $display("[TB] zero idle gap");
    mon = 1; doReset(); clearLog();
    applyStimulus(1, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    waitAccepts(3, 3 * 41 + 10); step();
    applyStimulus(1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00);
    waitTicks(30, 60);
    repeat (10) step();
    checkOutput("t6 ticks", 32'(tick_q.size()), 32'd30);
    checkOutput("t6 idle runs", 32'(low_q.size()), 32'd3);
    if (tick_q.size() == 30) begin
      bad = 0;
      for (int k = 1; k < 30; k++) if (tick_q[k] - tick_q[k-1] != ((k % 10 == 0) ? 5 : 4)) bad++;
      checkOutput("t6 tick spacing errors", 32'(bad), 32'd0);
    end
    if (low_q.size() == 3) begin
      checkOutput("t6 gap 1", 32'(low_q[1]), 32'd1);
      checkOutput("t6 gap 2", 32'(low_q[2]), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Transmit scheduler that shares one UART serializer (bit-tick-driven 9-bit shift register, tdo idle-high) between two byte requesters.
- Arbitrates round-robin and latches the winning byte onto data_wr.
- Generates the per-bit tick stream (start + 8 data + stop), then enforces a programmable idle gap before the next frame.
- Sits between software/peripheral byte sources and the serializer. Its bit_tick drives the serializer's bit-advance input.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (legal range >= 2; 868 = 100 MHz / 115200)
IDLE_BITS, 1, extra idle (mark) bit periods inserted after each stop bit (legal range 0..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
tx_enable  input  1  1 = new frames may be accepted; 0 = no new acceptance (an in-flight frame still completes)
req0_valid  input  1  requester 0 has a byte
req0_data  input  8  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle (valid & ready at edge = transfer)
req1_valid  input  1  requester 1 has a byte
req1_data  input  8  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle
data_wr  output  8  latched frame byte to serializer, stable for the whole frame
bit_tick  output  1  one-clk strobe per bit period, 10 per frame
frame_start  output  1  one-clk strobe coincident with the first bit_tick of a frame
busy  output  1  frame or idle gap in progress
grant_id  output  1  requester that owns the current/last frame

Behaviour:
- Reset (async, reset_n low): state IDLE, data_wr=8'h00, bit_tick=0, frame_start=0, busy=0, grant_id=0, last_grant=1, counters 0. Reset mid-frame aborts the frame immediately with no further ticks.
- FSM states: IDLE, SHIFT, GAP.
- IDLE arbitration (combinational):
  - Only one valid: that requester wins.
  - Both valid: winner = !last_grant.
  - reqN_ready = (state==IDLE) & tx_enable & reqN_valid & (winner==N). Never both high.
- Acceptance edge T0 (ready & valid):
  - data_wr <= winner's data; grant_id and last_grant <= winner.
  - cnt <= 0, bit_idx <= 0, state <= SHIFT.
- SHIFT:
  - bit_tick = (cnt==0); frame_start = (cnt==0 & bit_idx==0). Both are registered-state decodes, glitch-free.
  - cnt counts 0..CLKS_PER_BIT-1 and wraps; bit_idx increments on wrap.
  - On wrap with bit_idx==9: go to GAP (cnt=0, gap_idx=0) if IDLE_BITS>0, else to IDLE.
  - Ticks occur at T0+1+k*CLKS_PER_BIT, k=0..9. The SHIFT phase lasts exactly 10*CLKS_PER_BIT cycles.
- GAP: counts IDLE_BITS*CLKS_PER_BIT cycles with no ticks, then goes to IDLE.
- busy = (state != IDLE). It is high from T0+1 for (10+IDLE_BITS)*CLKS_PER_BIT cycles.
- Throughput: a new acceptance is possible in the first IDLE cycle. Back-to-back frame period = (10+IDLE_BITS)*CLKS_PER_BIT + 1 cycles.
- reqN_ready is 0 during SHIFT/GAP regardless of valid.
- Valid may drop before acceptance with no side effect; there is no request latching.
- tx_enable low during SHIFT/GAP: the frame and gap complete normally, and nothing further is accepted until tx_enable is 1.
- Counter widths:
  - cnt: $clog2(CLKS_PER_BIT).
  - bit_idx: 4 bits.
  - gap counter: wide enough for IDLE_BITS*CLKS_PER_BIT.
  - No wrap beyond the defined ranges.

Test Plan:
- CLKS_PER_BIT=4, IDLE_BITS=1; after reset, req0_valid=1, data 8'hA5 -> req0_ready for 1 cycle; data_wr=8'hA5; 10 bit_ticks spaced exactly 4 clks, first with frame_start; busy high 44 cycles; grant_id=0.
- Both valid continuously (req0=8'h11, req1=8'h22) -> grants alternate 0,1,0,1; data_wr alternates 11,22; frame period 45 cycles; ready never on both.
- Only req1 valid repeatedly -> req1 wins every frame; last_grant stays 1; no req0_ready.
- tx_enable deasserted at the 5th tick -> remaining 5 ticks and gap complete; no ready while enable=0; acceptance on the first cycle after enable returns to 1.
- reset_n pulsed low mid-SHIFT (after 3 ticks) -> outputs immediately at reset values; no further ticks; after release, req0 wins the first arbitration.
- IDLE_BITS=0, req0 always valid -> ticks continuous with spacing 4 except 5 cycles across each frame boundary; busy low exactly 1 cycle between frames.
